// File: rtl/exp4_fluxo_dados.sv
// Datapath for the memory-sequence game: address counter, ROM, switch register and play detector.
// Define EXP4_FLUXO_DADOS_DEBUG_EN to drive the db_* ports; otherwise they are tied to zero.
module exp4_fluxo_dados #(
  parameter int unsigned ADDR_LAST = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeraC,
  input  logic       contaC,
  input  logic       zeraR,
  input  logic       registraR,
  input  logic [3:0] chaves,
  output logic       fimC,
  output logic       chavesIgualMemoria,
  output logic       jogada_feita,
  output logic [3:0] db_contagem,
  output logic [3:0] db_memoria,
  output logic [3:0] db_chaves,
  output logic       db_tem_jogada
);

  localparam logic [3:0] LAST = 4'(ADDR_LAST);

  typedef enum logic {IDLE, HELD} det_t;

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] reg_q, reg_d;
  logic [3:0] mem_word;
  det_t       det_q, det_d;
  logic       jogada_q, jogada_d;
  logic       sinal;
  logic [3:0] rom [16];

  // One-hot walking pattern 1,2,4,8 repeated over the 16 addresses
  for (genvar k = 0; k < 16; k++) begin : g_rom
    assign rom[k] = 4'(1 << (k % 4));
  end

  assign mem_word = rom[cnt_q];
  assign sinal    = |chaves;

  always_comb begin
    cnt_d = cnt_q;
    if (zeraC)       cnt_d = '0;
    else if (contaC) cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
  end

  always_comb begin
    reg_d = reg_q;
    if (zeraR)          reg_d = '0;
    else if (registraR) reg_d = chaves;
  end

  always_comb begin
    det_d    = det_q;
    jogada_d = 1'b0;
    case (det_q)
      IDLE: if (sinal) begin
        det_d    = HELD;
        jogada_d = 1'b1;
      end
      HELD: if (!sinal) det_d = IDLE;
      default: det_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      reg_q    <= '0;
      det_q    <= IDLE;
      jogada_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      det_q    <= det_d;
      jogada_q <= jogada_d;
    end
  end

  assign fimC               = (cnt_q == LAST);
  assign chavesIgualMemoria = (reg_q == mem_word);
  assign jogada_feita       = jogada_q;

`ifdef EXP4_FLUXO_DADOS_DEBUG_EN
  assign db_contagem   = cnt_q;
  assign db_memoria    = mem_word;
  assign db_chaves     = reg_q;
  assign db_tem_jogada = sinal;
`else
  assign db_contagem   = '0;
  assign db_memoria    = '0;
  assign db_chaves     = '0;
  assign db_tem_jogada = 1'b0;
`endif

endmodule

// File: tb/tb_exp4_fluxo_dados.sv
// Scoreboard bench for exp4_fluxo_dados: driver pushes reference-model predictions, monitor checks at negedge.
module tb_exp4_fluxo_dados;

  localparam int LAST = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       zeraC = 1'b0, contaC = 1'b0, zeraR = 1'b0, registraR = 1'b0;
  logic [3:0] chaves = '0;
  logic       fimC, chavesIgualMemoria, jogada_feita, db_tem_jogada;
  logic [3:0] db_contagem, db_memoria, db_chaves;

  exp4_fluxo_dados #(.ADDR_LAST(LAST)) dut (
    .clock(clock), .reset(reset), .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR), .chaves(chaves),
    .fimC(fimC), .chavesIgualMemoria(chavesIgualMemoria), .jogada_feita(jogada_feita),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_chaves(db_chaves),
    .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fim, igual, jog, tem;
    logic [3:0] cont, mem, chv;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: counter modulo LAST+1, register, and "sinal was zero on the previous sample"
  int         m_cnt = 0;
  logic [3:0] m_reg = '0;
  logic       m_prev = 1'b0;
  logic       m_jog = 1'b0;

  function automatic logic [3:0] rom_of(input int a);
    logic [3:0] w;
    w = 4'(1 << (a % 4));
    return w;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_reg = '0; m_prev = 1'b0; m_jog = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else begin
      m_jog  = (chaves != 0) && !m_prev;
      m_prev = (chaves != 0);
      if (zeraC)       m_cnt = 0;
      else if (contaC) m_cnt = (m_cnt + 1) % (LAST + 1);
      if (zeraR)          m_reg = '0;
      else if (registraR) m_reg = chaves;
    end
  endtask

  task automatic step(input bit rst_n, input bit zc, input bit cc, input bit zr,
                      input bit rr, input logic [3:0] ch);
    exp_t e;
    @(posedge clock);
    model_edge();
    #1;
    reset = rst_n; zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = ch;
    if (!rst_n) model_reset();
    e.fim   = (m_cnt == LAST);
    e.igual = (m_reg == rom_of(m_cnt));
    e.jog   = m_jog;
`ifdef EXP4_FLUXO_DADOS_DEBUG_EN
    e.cont = 4'(m_cnt); e.mem = rom_of(m_cnt); e.chv = m_reg; e.tem = (ch != 0);
`else
    e.cont = '0; e.mem = '0; e.chv = '0; e.tem = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    if (got != want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk("fimC", int'(fimC), int'(e.fim));
        chk("chavesIgualMemoria", int'(chavesIgualMemoria), int'(e.igual));
        chk("jogada_feita", int'(jogada_feita), int'(e.jog));
        chk("db_contagem", int'(db_contagem), int'(e.cont));
        chk("db_memoria", int'(db_memoria), int'(e.mem));
        chk("db_chaves", int'(db_chaves), int'(e.chv));
        chk("db_tem_jogada", int'(db_tem_jogada), int'(e.tem));
      end
    end
  end

  initial begin : driver
    logic [3:0] ch;
    // Reset state, then clear the counter
    step(0, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 4'h0);
    step(1, 1, 0, 1, 0, 4'h0);
    // Count to LAST and wrap
    for (int i = 0; i < LAST + 1; i++) step(1, 0, 1, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 4'h0);
    // Counter to 2, load matching then non-matching switches
    step(1, 1, 0, 0, 0, 4'h0);
    step(1, 0, 1, 0, 0, 4'h0);
    step(1, 0, 1, 0, 0, 4'h0);
    step(1, 0, 0, 0, 1, 4'b0100);
    step(1, 0, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 1, 4'b1000);
    step(1, 0, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 4'h0);
    // Count to 5 then clear/count and clear/load together
    step(1, 1, 0, 0, 1, 4'b0011);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 4'h0);
    step(1, 1, 1, 1, 1, 4'b1111);
    step(1, 0, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 4'h0);
    // Play detector: 0010 held 5 cycles, zero, then 1000
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 4'b0010);
    step(1, 0, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 0, 4'b1000);
    step(1, 0, 0, 0, 0, 4'b1000);
    step(1, 0, 0, 0, 0, 4'b1001);
    step(1, 0, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 0, 0, 4'b0000);
    // Count 9, register 0100, then asynchronous reset between edges
    step(1, 1, 0, 1, 0, 4'h0);
    step(1, 0, 1, 0, 1, 4'b0100);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 0, 4'h0);
    // Randomized traffic
    ch = '0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) ch = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), ch);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exp4_fluxo_dados.md
EXP4_FLUXO_DADOS -- requirements
Module: exp4_fluxo_dados

Interface
REQ-001 Parameter: ADDR_LAST, default 15, last valid counter address (1..15).
REQ-002 Port: clock  input  1  system clock, rising-edge active.
REQ-003 Port: reset  input  1  asynchronous reset, active-low.
REQ-004 Port: zeraC  input  1  synchronous clear of the address counter.
REQ-005 Port: contaC  input  1  address counter increment enable.
REQ-006 Port: zeraR  input  1  synchronous clear of the switch register.
REQ-007 Port: registraR  input  1  load enable of the switch register.
REQ-008 Port: chaves  input  4  player switch inputs.
REQ-009 Port: fimC  output  1  high while counter equals ADDR_LAST.
REQ-010 Port: chavesIgualMemoria  output  1  register equals ROM word at counter address.
REQ-011 Port: jogada_feita  output  1  one-cycle pulse on the first nonzero chaves after all-zero.
REQ-012 Port: db_contagem  output  4  debug counter value.
REQ-013 Port: db_memoria  output  4  debug ROM word.
REQ-014 Port: db_chaves  output  4  debug register value.
REQ-015 Port: db_tem_jogada  output  1  debug OR of chaves.

Function
REQ-016 The 4-bit counter SHALL clear on zeraC, otherwise increment on contaC, otherwise hold; zeraC has priority.
REQ-017 Counter at ADDR_LAST with contaC (no zeraC) SHALL wrap to 0 on the next edge.
REQ-018 fimC SHALL be combinational: (counter == ADDR_LAST), no added latency.
REQ-019 The ROM SHALL be 16x4, combinational read: mem[k] = 4'b0001 << (k mod 4), i.e. 1,2,4,8 repeating.
REQ-020 The 4-bit switch register SHALL clear on zeraR, otherwise load chaves on registraR, otherwise hold; zeraR has priority.
REQ-021 chavesIgualMemoria SHALL be combinational: (register == mem[counter]).
REQ-022 jogada_feita SHALL use a two-state edge detector (IDLE, HELD) on sinal = |chaves.
REQ-023 IDLE->HELD when sinal=1, asserting jogada_feita for exactly that one cycle (registered output, 1-cycle latency after chaves sampled nonzero).
REQ-024 HELD->IDLE only when sinal=0; HELD holds jogada_feita=0 regardless of chaves value changes.
REQ-025 zeraC/contaC and zeraR/registraR SHALL act independently; all four asserted together is legal (both clear).
REQ-026 Counter and register values outside control pulses SHALL be stable; no output other than jogada_feita is registered beyond counter/register state.

Reset
REQ-027 reset low SHALL immediately force counter=0, register=0, detector=IDLE, jogada_feita=0, independent of clock.
REQ-028 Consequently during reset fimC=0 (ADDR_LAST>0), db_memoria=4'b0001, chavesIgualMemoria=0.
REQ-029 Reset asserted mid-sequence SHALL discard progress; first edge after release operates from reset state.
REQ-030 Reset deassertion SHALL be sampled at clock edges only for next-state updates; no pulse on jogada_feita caused by release alone if chaves=0.

Configuration
REQ-031 Macro EXP4_FLUXO_DADOS_DEBUG_EN SHALL control debug outputs.
REQ-032 Defined: db_contagem=counter, db_memoria=mem[counter], db_chaves=register, db_tem_jogada=|chaves.
REQ-033 Undefined: all db_* ports SHALL remain present and be driven constant 0; functional outputs unchanged.

Verification
REQ-034 reset low, then zeraC=1 one cycle -> counter 0, fimC=0, db_memoria=0001.
REQ-035 contaC held 15 cycles (ADDR_LAST=15) -> fimC=1 at count 15; one more contaC -> counter 0, fimC=0.
REQ-036 counter=2, chaves=0100, registraR pulse -> chavesIgualMemoria=1; chaves=1000, registraR -> 0.
REQ-037 zeraC and contaC together at count 5 -> counter 0; zeraR and registraR together -> register 0.
REQ-038 chaves 0000->0010 held 5 cycles->0000->1000 -> exactly two single-cycle jogada_feita pulses.
REQ-039 reset asserted asynchronously between edges at count 9, register 0100 -> all state 0 immediately.
